// File: rtl/bs_pkg.sv
// Shared state encoding and width helpers for the bit-serial inner-product engine.
package bs_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Wide enough for LANES full-scale products of AW x WMAX bits in any sign mode.
    function automatic int acc_width(input int aw, input int wmax, input int lanes);
        return aw + wmax + $clog2(lanes);
    endfunction

    function automatic int prec_width(input int wmax);
        return $clog2(wmax) + 1;
    endfunction

    localparam int PREC_W = prec_width(8);

endpackage

// File: rtl/bs_lane_sum.sv
// Masked, extended sum of LANES activations selected by one weight bit-plane.
// Purely combinational binary adder tree; leaves padded to a power of two with zeros.
module bs_lane_sum #(
    parameter int LANES = 16,
    parameter int AW    = 8,
    parameter int ACC_W = 20
) (
    input  logic [LANES*AW-1:0] act_vec,
    input  logic [LANES-1:0]    plane,
    input  logic                a_signed,
    output logic [ACC_W-1:0]    psum
);

    localparam int NP = 1 << $clog2(LANES);

    // Heap layout: node[1] is the root, leaves live at node[NP .. 2*NP-1].
    logic [ACC_W-1:0] node [1:2*NP-1];

    genvar i;
    generate
        for (i = 0; i < NP; i++) begin : g_leaf
            if (i < LANES) begin : g_act
                logic [ACC_W-1:0] ext;
                assign ext = {{(ACC_W-AW){a_signed & act_vec[i*AW+AW-1]}}, act_vec[i*AW +: AW]};
                assign node[NP+i] = plane[i] ? ext : '0;
            end else begin : g_pad
                assign node[NP+i] = '0;
            end
        end
        for (i = 1; i < NP; i++) begin : g_tree
            assign node[i] = node[2*i] + node[2*i+1];
        end
    endgenerate

    assign psum = node[1];

endmodule

// File: rtl/bs_sip_engine.sv
// Bit-serial dot product: activations latched at start, weight bit-planes MSB first.
// Result valid the cycle after the last plane; held until out_rdy; abort cancels from any state.
module bs_sip_engine
    import bs_pkg::*;
#(
    parameter int LANES = 16,
    parameter int AW    = 8,
    parameter int WMAX  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    output logic                                 start_rdy,
    input  logic [$clog2(WMAX):0]                prec,
    input  logic                                 a_signed,
    input  logic                                 w_signed,
    input  logic [LANES*AW-1:0]                  act_vec,
    input  logic                                 plane_vld,
    output logic                                 plane_rdy,
    input  logic [LANES-1:0]                     plane,
    input  logic                                 abort,
    output logic                                 out_vld,
    input  logic                                 out_rdy,
    output logic [AW+WMAX+$clog2(LANES)-1:0]     out_data
);

    localparam int ACC_W = acc_width(AW, WMAX, LANES);
    localparam int PW    = prec_width(WMAX);

    logic [1:0]          state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [PW-1:0]       cnt_q, cnt_d;
    logic [LANES*AW-1:0] act_q, act_d;
    logic                a_sgn_q, a_sgn_d;
    logic                w_sgn_q, w_sgn_d;
    logic                first_q, first_d;
    logic [PW-1:0]       eff_prec;
    logic [ACC_W-1:0]    psum;

    always_comb begin
        eff_prec = prec;
        if (prec == '0 || prec > PW'(WMAX)) begin
            eff_prec = PW'(WMAX);
        end
    end

    bs_lane_sum #(
        .LANES (LANES),
        .AW    (AW),
        .ACC_W (ACC_W)
    ) u_lane_sum (
        .act_vec  (act_q),
        .plane    (plane),
        .a_signed (a_sgn_q),
        .psum     (psum)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        a_sgn_d = a_sgn_q;
        w_sgn_d = w_sgn_q;
        first_d = first_q;
        if (abort) begin
            state_d = S_IDLE;
            acc_d   = '0;
            first_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        act_d   = act_vec;
                        a_sgn_d = a_signed;
                        w_sgn_d = w_signed;
                        acc_d   = '0;
                        cnt_d   = eff_prec - 1'b1;
                        first_d = 1'b1;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (plane_vld) begin
                        // The MSB plane of a signed weight carries negative weight.
                        if (first_q && w_sgn_q) begin
                            acc_d = (acc_q << 1) - psum;
                        end else begin
                            acc_d = (acc_q << 1) + psum;
                        end
                        first_d = 1'b0;
                        if (cnt_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_rdy) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
            a_sgn_q <= 1'b0;
            w_sgn_q <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            a_sgn_q <= a_sgn_d;
            w_sgn_q <= w_sgn_d;
            first_q <= first_d;
        end
    end

    assign start_rdy = (state_q == S_IDLE);
    assign plane_rdy = (state_q == S_RUN);
    assign out_vld   = (state_q == S_DONE);
    assign out_data  = acc_q;

endmodule
